hc4_prog_loader: RTL and testbench
==================================

# hc4_prog_loader

Upstream boot stage of the HC4 CPU. Receives a framed program image over a byte stream from the host or debug link, writes it into the HC4 program memory, verifies an 8-bit checksum, and only then releases the CPU's active-low reset. A corrupted or malformed image leaves the CPU held in reset and raises a sticky error.

## Interface
- `ADDR_WIDTH`, default 12: program memory address width, matches the HC4 PC width; legal range 9..16.
- `SYNC_BYTE`, default 8'hA5: frame start marker.
- `RESET_HOLD`, default 4: cycles between checksum pass and release of `cpu_nReset`; legal range ≥1.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `in_data`  in  8  host stream byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader accepts `in_data` at this edge.
- `prog_addr`  out  ADDR_WIDTH  program memory write address.
- `prog_data`  out  8  program memory write data.
- `prog_we`  out  1  one-cycle write strobe.
- `cpu_nReset`  out  1  to HC4 `nReset`; low holds the CPU.
- `busy`  out  1  a frame is in progress (states LEN_HI..HOLD).
- `done`  out  1  last frame loaded and verified; cleared when a new frame starts.
- `err`  out  1  sticky: last frame failed; cleared when a new frame starts.

## Operation
- A transfer occurs at a rising edge with `in_valid && in_ready`.
- Frame: `SYNC_BYTE`, LEN_HI, LEN_LO, N data bytes, CHK. `{LEN_HI, LEN_LO}` holds N-1; bits above ADDR_WIDTH-1 must be zero. N ranges 1..2^ADDR_WIDTH.
- Data byte k (0-based) is written to address k.
- Checksum: (sum of data bytes + CHK) mod 256 must equal 0.
- States:
  - IDLE: bytes other than `SYNC_BYTE` are discarded. On sync: clear `done`/`err`, drive `cpu_nReset` low, go to LEN_HI.
  - LEN_HI: latch the byte. If any bit at position ≥ ADDR_WIDTH-8 is set, set `err` and go to IDLE; otherwise go to LEN_LO.
  - LEN_LO: latch the byte, clear index and sum, go to DATA.
  - DATA: accept a byte, add it to the sum (8-bit wrap), register the write. After index N-1, go to CHK.
  - CHK: on pass, go to HOLD; on fail, set `err` and go to IDLE.
  - HOLD: count RESET_HOLD cycles, then set `done`, raise `cpu_nReset`, go to RUN.
  - RUN: CPU runs. Bytes other than `SYNC_BYTE` are discarded. `SYNC_BYTE` reloads the program, behaving exactly as in IDLE.
- A sync byte inside DATA is treated as data. There is no resync mid-frame.
- The CPU stays in reset from power-up until the first frame verifies. After an error, `cpu_nReset` stays low.

## Timing
- Reset values (`Reset` high at an edge):
  - state IDLE, `in_ready` 0
  - `prog_we` 0, `prog_addr` 0, `prog_data` 0
  - `cpu_nReset` 0, `busy` 0, `done` 0, `err` 0
- `in_ready` is registered. It is 1 in every state except:
  - the cycle after a DATA transfer, when the write is in flight;
  - all of HOLD.
- Peak data rate is one byte per 2 cycles.
- Write timing: data byte accepted at edge t gives `prog_we`=1 with `prog_addr`=k and `prog_data`=byte during cycle t..t+1. `prog_we` is low otherwise.
- CHK accepted at edge t: `err` (fail) or HOLD entry (pass) is visible after edge t.
- On pass, `cpu_nReset` and `done` go high after edge t+RESET_HOLD+1.
- Sync accepted in RUN: `cpu_nReset` goes low after the same edge.
- `Reset` asserted mid-frame returns to IDLE. Memory contents are then undefined and the CPU stays held.
- Index counter is ADDR_WIDTH+1 bits so that N = 2^ADDR_WIDTH does not wrap early.

## Test plan
- After reset, send A5 00 02 10 20 30 A0 → three `prog_we` pulses: (0,10), (1,20), (2,30). Then `done`=1, and `cpu_nReset` rises RESET_HOLD+1 cycles after the CHK transfer; `err`=0.
- Same frame with CHK=A1 → three writes occur, `err`=1, `done`=0, `cpu_nReset` stays 0. A following good frame clears `err` and releases the CPU.
- Send 00 FF 3C, then A5 00 00 7E 82 → the leading bytes are ignored, one write (0,7E), then release.
- Send A5 10 00 → `err`=1 after LEN_HI, no writes, return to IDLE.
- Load a good frame, let the CPU run, then send A5 → `cpu_nReset` drops the next cycle and `done` clears. Reload completes normally.
- Send A5 0F FF with 4096 data bytes and a correct CHK, with `in_valid` toggled randomly → writes cover addresses 0..4095 exactly once each and `done`=1. Assert `Reset` mid-DATA in a repeat run → all outputs return to reset values.

Source files
------------

// File: rtl/hc4_prog_loader.sv
// HC4 boot loader: framed byte stream -> program memory,
// checksum verify, then release of the CPU reset.
module hc4_prog_loader #(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
  parameter int          RESET_HOLD = 4
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] prog_addr,
  output logic [7:0]            prog_data,
  output logic                  prog_we,
  output logic                  cpu_nReset,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LENHI = 3'd1;
  localparam logic [2:0] S_LENLO = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_CHK   = 3'd4;
  localparam logic [2:0] S_HOLD  = 3'd5;
  localparam logic [2:0] S_RUN   = 3'd6;

  localparam int HW = $clog2(RESET_HOLD + 1);
  localparam logic [7:0] HI_MASK =
    8'((16'h00FF << (ADDR_WIDTH - 8)) & 16'h00FF);

  logic [2:0]            st_q, st_d;
  logic                  rdy_q, rdy_d;
  logic [7:0]            lenhi_q, lenhi_d;
  logic [15:0]           len_q, len_d;
  logic [ADDR_WIDTH:0]   idx_q, idx_d;
  logic [7:0]            sum_q, sum_d;
  logic [HW-1:0]         hcnt_q, hcnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            pdat_q, pdat_d;
  logic                  nres_q, nres_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic       fire;
  logic [7:0] chk_sum;
  logic       last;

  assign fire    = in_valid && rdy_q;
  assign chk_sum = sum_q + in_data;
  assign last    = (17'(idx_q) == {1'b0, len_q});

  // Frame parser next-state and datapath updates
  always_comb begin
    st_d    = st_q;
    lenhi_d = lenhi_q;
    len_d   = len_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    hcnt_d  = hcnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    pdat_d  = pdat_q;
    nres_d  = nres_q;
    done_d  = done_q;
    err_d   = err_q;
    unique case (st_q)
      S_IDLE, S_RUN: begin
        if (fire && in_data == SYNC_BYTE) begin
          done_d = 1'b0;
          err_d  = 1'b0;
          nres_d = 1'b0;
          st_d   = S_LENHI;
        end
      end
      S_LENHI: begin
        if (fire) begin
          lenhi_d = in_data;
          if (|(in_data & HI_MASK)) begin
            err_d = 1'b1;
            st_d  = S_IDLE;
          end else begin
            st_d = S_LENLO;
          end
        end
      end
      S_LENLO: begin
        if (fire) begin
          len_d = {lenhi_q, in_data};
          idx_d = '0;
          sum_d = '0;
          st_d  = S_DATA;
        end
      end
      S_DATA: begin
        if (fire) begin
          sum_d  = chk_sum;
          we_d   = 1'b1;
          addr_d = idx_q[ADDR_WIDTH-1:0];
          pdat_d = in_data;
          if (last) st_d = S_CHK;
          else      idx_d = idx_q + 1'b1;
        end
      end
      S_CHK: begin
        if (fire) begin
          if (chk_sum == 8'd0) begin
            hcnt_d = '0;
            st_d   = S_HOLD;
          end else begin
            err_d = 1'b1;
            st_d  = S_IDLE;
          end
        end
      end
      S_HOLD: begin
        if (hcnt_q == HW'(RESET_HOLD)) begin
          done_d = 1'b1;
          nres_d = 1'b1;
          st_d   = S_RUN;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      default: st_d = S_IDLE;
    endcase
    rdy_d = (st_d != S_HOLD) && !(st_q == S_DATA && fire);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (Reset) begin
      st_q    <= S_IDLE;
      rdy_q   <= 1'b0;
      lenhi_q <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      sum_q   <= '0;
      hcnt_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      pdat_q  <= '0;
      nres_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      rdy_q   <= rdy_d;
      lenhi_q <= lenhi_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      hcnt_q  <= hcnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      pdat_q  <= pdat_d;
      nres_q  <= nres_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign in_ready   = rdy_q;
  assign prog_we    = we_q;
  assign prog_addr  = addr_q;
  assign prog_data  = pdat_q;
  assign cpu_nReset = nres_q;
  assign done       = done_q;
  assign err        = err_q;
  assign busy       = (st_q == S_LENHI) || (st_q == S_LENLO) ||
                      (st_q == S_DATA)  || (st_q == S_CHK)   ||
                      (st_q == S_HOLD);

endmodule

// File: tb/tb_hc4_prog_loader.sv
// Directed bench for hc4_prog_loader: frames, errors,
// reload from RUN, full 4096-byte image, mid-frame reset.
module tb_hc4_prog_loader;

  logic        clk = 1'b0;
  logic        Reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] prog_addr;
  logic [7:0]  prog_data;
  logic        prog_we;
  logic        cpu_nReset;
  logic        busy;
  logic        done;
  logic        err;

  int errors = 0;
  int checks = 0;

  logic [19:0] wq[$];
  int          hits[4096];

  hc4_prog_loader dut (
    .clk        (clk),
    .Reset      (Reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .prog_we    (prog_we),
    .cpu_nReset (cpu_nReset),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (prog_we === 1'b1 && Reset === 1'b0) begin
      wq.push_back({prog_addr, prog_data});
      hits[prog_addr] = hits[prog_addr] + 1;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    wq.delete();
    foreach (hits[i]) hits[i] = 0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one byte and hold it until accepted, bounded.
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    assert (n < 100) else begin
      errors++;
      $error("FAIL handshake observed=%0d expected=<100", n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rdy"},  in_ready,   0);
    chk({tag, "_we"},   prog_we,    0);
    chk({tag, "_addr"}, prog_addr,  0);
    chk({tag, "_data"}, prog_data,  0);
    chk({tag, "_nrst"}, cpu_nReset, 0);
    chk({tag, "_busy"}, busy,       0);
    chk({tag, "_done"}, done,       0);
    chk({tag, "_err"},  err,        0);
  endtask

  initial begin
    logic [7:0] s;
    logic [7:0] b;
    Reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    clr();
    cyc(3);
    chk_reset("rst");
    Reset = 1'b0;
    cyc(1);
    chk("idle_rdy", in_ready, 1);

    // Good three-byte frame
    send(8'hA5);
    chk("t1_busy", busy, 1);
    send(8'h00); send(8'h02);
    send(8'h10); send(8'h20); send(8'h30);
    send(8'hA0);
    chk("t1_hold_rdy", in_ready, 0);
    chk("t1_hold_nrst", cpu_nReset, 0);
    cyc(4);
    chk("t1_pre_nrst", cpu_nReset, 0);
    chk("t1_pre_done", done, 0);
    cyc(1);
    chk("t1_nrst", cpu_nReset, 1);
    chk("t1_done", done, 1);
    chk("t1_err", err, 0);
    chk("t1_busy_run", busy, 0);
    chk("t1_nw", wq.size(), 3);
    chk("t1_w0", wq[0], 20'h00010);
    chk("t1_w1", wq[1], 20'h00120);
    chk("t1_w2", wq[2], 20'h00230);

    // Bad checksum, then a good frame recovers
    clr();
    send(8'hA5);
    chk("t2_sync_nrst", cpu_nReset, 0);
    chk("t2_sync_done", done, 0);
    send(8'h00); send(8'h02);
    send(8'h10); send(8'h20); send(8'h30);
    send(8'hA1);
    chk("t2_err", err, 1);
    chk("t2_done", done, 0);
    chk("t2_busy", busy, 0);
    chk("t2_nw", wq.size(), 3);
    cyc(8);
    chk("t2_nrst", cpu_nReset, 0);
    send(8'hA5);
    chk("t2_err_clr", err, 0);
    send(8'h00); send(8'h02);
    send(8'h10); send(8'h20); send(8'h30);
    send(8'hA0);
    cyc(5);
    chk("t2_rel_nrst", cpu_nReset, 1);
    chk("t2_rel_err", err, 0);

    // Junk in RUN is ignored; sync reloads
    clr();
    send(8'h00); send(8'hFF); send(8'h3C);
    chk("t3_junk_nw", wq.size(), 0);
    chk("t3_junk_nrst", cpu_nReset, 1);
    chk("t3_junk_done", done, 1);
    send(8'hA5);
    chk("t3_drop_nrst", cpu_nReset, 0);
    chk("t3_drop_done", done, 0);
    send(8'h00); send(8'h00);
    send(8'h7E); send(8'h82);
    cyc(5);
    chk("t3_nrst", cpu_nReset, 1);
    chk("t3_done", done, 1);
    chk("t3_nw", wq.size(), 1);
    chk("t3_w0", wq[0], 20'h0007E);

    // Oversize length
    clr();
    send(8'hA5); send(8'h10);
    chk("t4_err", err, 1);
    chk("t4_busy", busy, 0);
    chk("t4_rdy", in_ready, 1);
    send(8'h00);
    chk("t4_nw", wq.size(), 0);
    chk("t4_nrst", cpu_nReset, 0);

    // Full-size image with random gaps
    clr();
    s = 8'h00;
    send(8'hA5); send(8'h0F); send(8'hFF);
    for (int i = 0; i < 4096; i++) begin
      in_valid = 1'b0;
      cyc($urandom_range(0, 2));
      b = 8'((i * 7) + (i >> 8) + 3);
      s = s + b;
      send(b);
    end
    chk("t5_chk_busy", busy, 1);
    send(8'h00 - s);
    cyc(5);
    chk("t5_done", done, 1);
    chk("t5_err", err, 0);
    chk("t5_nrst", cpu_nReset, 1);
    chk("t5_nw", wq.size(), 4096);
    begin
      int bad;
      bad = 0;
      foreach (hits[i]) if (hits[i] != 1) bad++;
      chk("t5_cover", bad, 0);
    end
    chk("t5_last", wq[4095], {12'hFFF, 8'((4095 * 7) + 15 + 3)});

    // Reset in the middle of DATA
    clr();
    send(8'hA5); send(8'h0F); send(8'hFF);
    for (int i = 0; i < 100; i++) send(8'(i + 1));
    chk("t6_busy", busy, 1);
    Reset = 1'b1;
    cyc(1);
    chk_reset("t6");
    Reset = 1'b0;
    cyc(2);
    chk("t6_rdy", in_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
